lcd_display_nios2_qsys_0_jtag_scan_master: RTL and testbench

//  Initiator end of the Nios II virtual-JTAG debug link. Accepts IR/DR scan commands from a

---
 rtl/lcd_display_nios2_qsys_0_jtag_scan_master.sv | 190 +++++++++++++++++++
 tb/tb_lcd_display_nios2_qsys_0_jtag_scan_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_display_nios2_qsys_0_jtag_scan_master.sv
// lcd_display_nios2_qsys_0_jtag_scan_master
//
// Initiator end of the Nios II virtual-JTAG debug link. It takes one IR/DR
// scan command at a time from a host-side controller and plays it into the
// debug module's TCK-side logic through the vji_* virtual-state signals:
// UIR -> CDR -> SDR (DR_WIDTH ticks) -> UDR -> RTI. It then returns the
// captured DR word and the ir_out status. It can stand in for sld_virtual_jtag
// in simulation benches and on-chip debug controllers.
//
// Optional feature (compile-time macro SCAN_MASTER_SKIP_IR_EN):
//   When defined, the UIR tick is skipped if cmd_ir already equals vji_ir_in
//   and at least one scan has completed since reset. The first scan after
//   reset always issues UIR.
//
// Parameters
//   DR_WIDTH  scan-chain length in bits (default 38)
//   IR_WIDTH  virtual instruction width (default 2)
//   TCK_DIV   clk cycles per TCK half-period, 1..255 (default 4)
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command channel; cmd_ir, cmd_dr payload
//   rsp_valid/rsp_ready     response channel; rsp_dr, rsp_ir payload
//   vji_tck, vji_tdi        generated test clock and serial data out
//   vji_tdo, vji_ir_out     serial data and status from the debug module
//   vji_ir_in               current virtual instruction (held after scan)
//   vji_uir/cdr/sdr/udr/rti virtual state flags, exactly one high while busy
//   state_dbg               FSM state for checkers
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and payload stable until that edge, and valid
// never waits on ready. cmd_ready is high only in IDLE. rsp_valid is high
// only in RSP, and rsp_dr/rsp_ir do not change while it is high.

module lcd_display_nios2_qsys_0_jtag_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [2:0]          state_dbg
);

  localparam int              BW       = $clog2(DR_WIDTH + 1);
  localparam logic [7:0]      DIV_LAST = 8'(TCK_DIV - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RTI  = 3'd5,
    S_RSP  = 3'd6
  } state_t;

  state_t              state, state_next;
  logic [7:0]          div_cnt, div_next;
  logic                tck_next;
  logic [BW-1:0]       bit_cnt, bit_next;
  logic [DR_WIDTH-1:0] dr_q;
  logic                accept, scanning, tck_rise, tick_end, skip_uir;

  assign accept    = cmd_valid && cmd_ready;
  assign scanning  = (state == S_UIR) || (state == S_CDR) || (state == S_SDR) ||
                     (state == S_UDR) || (state == S_RTI);
  // A tick is TCK_DIV cycles low followed by TCK_DIV cycles high. The rise is
  // the last low cycle and the tick end is the last high cycle.
  assign tck_rise  = scanning && !vji_tck && (div_cnt == DIV_LAST);
  assign tick_end  = scanning &&  vji_tck && (div_cnt == DIV_LAST);
  assign state_dbg = state;

`ifdef SCAN_MASTER_SKIP_IR_EN
  logic scan_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_done <= 1'b0;
    end else if ((state == S_RTI) && tick_end) begin
      scan_done <= 1'b1;
    end
  end

  assign skip_uir = scan_done && (cmd_ir == vji_ir_in);
`else
  assign skip_uir = 1'b0;
`endif

  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    div_next   = 8'd0;
    tck_next   = 1'b0;
    if (scanning) begin
      if (div_cnt == DIV_LAST) begin
        div_next = 8'd0;
        tck_next = ~vji_tck;
      end else begin
        div_next = div_cnt + 8'd1;
        tck_next = vji_tck;
      end
    end
    case (state)
      S_IDLE: if (accept) state_next = skip_uir ? S_CDR : S_UIR;
      S_UIR:  if (tick_end) state_next = S_CDR;
      S_CDR: begin
        if (tick_end) begin
          state_next = S_SDR;
          bit_next   = '0;
        end
      end
      S_SDR: begin
        // Leave after the tick that sampled bit DR_WIDTH-1, which gives
        // exactly DR_WIDTH rising edges in SDR.
        if (tick_end) begin
          if (bit_cnt == BIT_LAST) state_next = S_UDR;
          else                     bit_next   = bit_cnt + 1'b1;
        end
      end
      S_UDR:  if (tick_end) state_next = S_RTI;
      S_RTI:  if (tick_end) state_next = S_RSP;
      S_RSP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state. Flags and tdi therefore
  // switch on the same edge that starts a tick, where tck falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= '0;
      dr_q      <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dr    <= '0;
      rsp_ir    <= '0;
      vji_tck   <= 1'b0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      vji_rti   <= 1'b0;
    end else begin
      state     <= state_next;
      div_cnt   <= div_next;
      bit_cnt   <= bit_next;
      vji_tck   <= tck_next;
      cmd_ready <= (state_next == S_IDLE);
      rsp_valid <= (state_next == S_RSP);
      vji_uir   <= (state_next == S_UIR);
      vji_cdr   <= (state_next == S_CDR);
      vji_sdr   <= (state_next == S_SDR);
      vji_udr   <= (state_next == S_UDR);
      vji_rti   <= (state_next == S_RTI);
      vji_tdi   <= (state_next == S_SDR) ? dr_q[bit_next] : 1'b0;
      if (accept) begin
        dr_q      <= cmd_dr;
        vji_ir_in <= cmd_ir;
      end
      if (tck_rise && (state == S_CDR)) rsp_ir <= vji_ir_out;
      // Shift in at the MSB so that bit k lands at rsp_dr[k] after DR_WIDTH shifts.
      if (tck_rise && (state == S_SDR)) rsp_dr <= {vji_tdo, rsp_dr[DR_WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_lcd_display_nios2_qsys_0_jtag_scan_master.sv
module tb_lcd_display_nios2_qsys_0_jtag_scan_master;
  localparam int DW = 38;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- DUT (TCK_DIV = 1) ----------------
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [IW-1:0] cmd_ir, rsp_ir, vji_ir_in, vji_ir_out;
  logic [DW-1:0] cmd_dr, rsp_dr;
  logic          vji_tck, vji_tdi, vji_tdo;
  logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [2:0]    state_dbg;
  logic [1:0]    tdo_mode;   // 0 loopback, 1 tied high, 2 tied low

  assign vji_tdo = (tdo_mode == 2'd0) ? vji_tdi : (tdo_mode == 2'd1);

  lcd_display_nios2_qsys_0_jtag_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir(rsp_ir),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti),
    .state_dbg(state_dbg)
  );

  // ---------------- DUT (TCK_DIV = 4), loopback ----------------
  logic          c4_valid, c4_ready, r4_valid, r4_ready;
  logic [IW-1:0] c4_ir, r4_ir, ir_in4;
  logic [DW-1:0] c4_dr, r4_dr;
  logic          tck4, tdi4, uir4, cdr4, sdr4, udr4, rti4;
  logic [2:0]    state4;

  lcd_display_nios2_qsys_0_jtag_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(c4_valid), .cmd_ready(c4_ready), .cmd_ir(c4_ir), .cmd_dr(c4_dr),
    .rsp_valid(r4_valid), .rsp_ready(r4_ready), .rsp_dr(r4_dr), .rsp_ir(r4_ir),
    .vji_tck(tck4), .vji_tdi(tdi4), .vji_tdo(tdi4),
    .vji_ir_in(ir_in4), .vji_ir_out(2'b01),
    .vji_uir(uir4), .vji_cdr(cdr4), .vji_sdr(sdr4), .vji_udr(udr4), .vji_rti(rti4),
    .state_dbg(state4)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- monitors (sampled on falling clk edge) ----------------
  int   rises, uir_n, cdr_n, udr_n, rti_n, hot_viol;
  logic tck_p = 1'b0, uir_p = 1'b0, cdr_p = 1'b0, udr_p = 1'b0, rti_p = 1'b0;

  always @(negedge clk) begin
    if (vji_tck && !tck_p) rises++;
    if (vji_uir && !uir_p) uir_n++;
    if (vji_cdr && !cdr_p) cdr_n++;
    if (vji_udr && !udr_p) udr_n++;
    if (vji_rti && !rti_p) rti_n++;
    if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) hot_viol++;
    if (!cmd_ready && !rsp_valid &&
        $countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) != 1) hot_viol++;
    tck_p = vji_tck; uir_p = vji_uir; cdr_p = vji_cdr; udr_p = vji_udr; rti_p = vji_rti;
  end

  int   rise4 = 0, run4 = 0, run_viol4 = 0, tdi_viol4 = 0;
  logic tck4_p = 1'b0, tdi4_p = 1'b0;

  always @(negedge clk) begin
    if (tck4 && !tck4_p) rise4++;
    if (tdi4 != tdi4_p && !(tck4_p && !tck4)) tdi_viol4++;
    if (c4_ready) begin
      run4 = 0;
    end else if (tck4 == tck4_p) begin
      run4++;
    end else begin
      if (run4 != 4) run_viol4++;
      run4 = 1;
    end
    tck4_p = tck4;
    tdi4_p = tdi4;
  end

  task automatic clr_mon();
    rises = 0; uir_n = 0; cdr_n = 0; udr_n = 0; rti_n = 0; hot_viol = 0;
  endtask

  // ---------------- reference model for the UIR skip ----------------
  bit            skip_en;
  bit            done_since_reset;
  logic [IW-1:0] last_ir;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    done_since_reset = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Offers one command. lat counts rising edges from the accept edge up to and
  // including the edge after which rsp_valid is seen high.
  task automatic do_scan(input logic [IW-1:0] ir, input logic [DW-1:0] dr, output int lat);
    @(negedge clk);
    #1;
    clr_mon();
    chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    cmd_valid = 1'b0;
    cmd_ir = ~ir;
    cmd_dr = ~dr;     // changes after accept must be ignored
    while (!rsp_valid && lat < 2000) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic take_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_after_take", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_after_take", 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_scan(input string name, input logic [IW-1:0] ir, input logic [DW-1:0] dr,
                          input logic [1:0] mode, input logic [IW-1:0] irout,
                          input logic [DW-1:0] exp_dr, input logic [IW-1:0] exp_ir,
                          input bit take);
    int lat;
    int n_uir;
    n_uir = (skip_en && done_since_reset && ir == last_ir) ? 0 : 1;
    tdo_mode = mode;
    vji_ir_out = irout;
    exp_q.push_back(exp_dr);
    do_scan(ir, dr, lat);
    chk({name, "_latency"}, 64'(lat), 64'((n_uir + DW + 3) * 2 + 1));
    chk({name, "_rsp_dr"},  64'(rsp_dr), 64'(exp_q.pop_front()));
    chk({name, "_rsp_ir"},  64'(rsp_ir), 64'(exp_ir));
    chk({name, "_tck_rises"}, 64'(rises), 64'(n_uir + DW + 3));
    chk({name, "_uir_pulses"}, 64'(uir_n), 64'(n_uir));
    chk({name, "_cdr_udr_rti"}, {cdr_n[15:0], udr_n[15:0], rti_n[15:0]}, {16'd1, 16'd1, 16'd1});
    chk({name, "_onehot"}, 64'(hot_viol), 64'd0);
    chk({name, "_ir_in"}, 64'(vji_ir_in), 64'(ir));
    chk({name, "_tdi_idle"}, 64'(vji_tdi), 64'd0);
    last_ir = ir;
    done_since_reset = 1'b1;
    if (take) take_rsp();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [IW-1:0] ir;
    logic [DW-1:0] dr;
    logic [1:0]    mode;
    logic [IW-1:0] irout;
    logic [DW-1:0] exp_dr;
    logic [IW-1:0] exp_ir;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [DW-1:0] held_dr;
    logic [IW-1:0] held_ir;
    int            viol;
    int            lat;
    bit            timed_out;

`ifdef SCAN_MASTER_SKIP_IR_EN
    skip_en = 1'b1;
`else
    skip_en = 1'b0;
`endif
    done_since_reset = 1'b0;
    last_ir = '0;
    clr_mon();
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b0;
    tdo_mode = 2'd0; vji_ir_out = '0;
    c4_valid = 1'b0; c4_ir = '0; c4_dr = '0; r4_ready = 1'b0;

    vecs[0] = '{2'b01, 38'h2A_5555_AAAA, 2'd0, 2'b00, 38'h2A_5555_AAAA, 2'b00};
    vecs[1] = '{2'b10, 38'h12_3456_789A, 2'd1, 2'b10, 38'h3F_FFFF_FFFF, 2'b10};
    vecs[2] = '{2'b00, 38'h3F_FFFF_FFFF, 2'd0, 2'b01, 38'h3F_FFFF_FFFF, 2'b01};
    vecs[3] = '{2'b11, 38'h00_0000_0001, 2'd0, 2'b11, 38'h00_0000_0001, 2'b11};
    vecs[4] = '{2'b01, 38'h20_0000_0000, 2'd0, 2'b10, 38'h20_0000_0000, 2'b10};
    vecs[5] = '{2'b10, 38'h15_A5C3_0F96, 2'd2, 2'b01, 38'h00_0000_0000, 2'b01};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_rsp", {rsp_valid, rsp_ir, rsp_dr}, 64'd0);
    chk("reset_vji", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti},
        64'd0);
    chk("reset_state", 64'(state_dbg), 64'd0);
    reset_n = 1'b1;

    // Table-driven scans.
    for (int i = 0; i < 6; i++) begin
      run_scan($sformatf("vec%0d", i), vecs[i].ir, vecs[i].dr, vecs[i].mode, vecs[i].irout,
               vecs[i].exp_dr, vecs[i].exp_ir, 1'b1);
    end

    // Response held off for 20 cycles while another command is offered.
    run_scan("hold", 2'b00, 38'h12_3456_789A, 2'd0, 2'b11, 38'h12_3456_789A, 2'b11, 1'b0);
    held_dr = rsp_dr;
    held_ir = rsp_ir;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 3) begin
        cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_dr = 38'h01_0101_0101;
      end
      if (!rsp_valid || rsp_dr !== held_dr || rsp_ir !== held_ir || cmd_ready) viol++;
    end
    cmd_valid = 1'b0;
    chk("hold_stable", 64'(viol), 64'd0);
    take_rsp();
    chk("hold_extra_cmd_ignored", {vji_ir_in, rsp_dr}, {2'b00, 38'h12_3456_789A});

    // Reset during SDR bit 17 aborts the scan.
    tdo_mode = 2'd0;
    @(negedge clk);
    #1;
    clr_mon();
    cmd_ir = 2'b01; cmd_dr = 38'h2A_AAAA_5555; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rises >= 19) begin
        timed_out = 1'b0;
        break;
      end
    end
    chk("abort_reach_bit17", 64'(timed_out), 64'd0);
    @(posedge clk);   // tick 19 (SDR bit 17) starts here
    @(negedge clk);
    chk("abort_in_sdr", 64'(vji_sdr), 64'd1);
    reset_n = 1'b0;
    done_since_reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_outputs", {rsp_valid, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr,
                          vji_udr, vji_rti, rsp_ir, rsp_dr}, 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) viol++;
    end
    chk("abort_no_rsp", 64'(viol), 64'd0);
    run_scan("after_abort", 2'b01, 38'h0F_0F0F_0F0F, 2'd0, 2'b10, 38'h0F_0F0F_0F0F, 2'b10, 1'b1);

    // Two scans with the same IR; with the skip feature the second has no UIR.
    do_reset();
    run_scan("same_ir_a", 2'b11, 38'h3C_3C3C_3C3C, 2'd0, 2'b01, 38'h3C_3C3C_3C3C, 2'b01, 1'b1);
    run_scan("same_ir_b", 2'b11, 38'h01_2345_6789, 2'd0, 2'b01, 38'h01_2345_6789, 2'b01, 1'b1);

    // TCK_DIV = 4 instance: tck phases, tdi timing, latency and data.
    @(negedge clk);
    #1;
    rise4 = 0;
    c4_ir = 2'b10; c4_dr = 38'h2B_6D5A_C3E1; c4_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    c4_valid = 1'b0;
    c4_dr = '0;
    while (!r4_valid && lat < 3000) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk("div4_latency", 64'(lat), 64'(42 * 2 * 4 + 1));
    chk("div4_rsp_dr", 64'(r4_dr), 64'(38'h2B_6D5A_C3E1));
    chk("div4_rsp_ir", 64'(r4_ir), 64'd1);
    chk("div4_rises", 64'(rise4), 64'd42);
    chk("div4_half_period", 64'(run_viol4), 64'd0);
    chk("div4_tdi_at_fall", 64'(tdi_viol4), 64'd0);
    @(negedge clk);
    r4_ready = 1'b1;
    @(posedge clk);
    #1;
    r4_ready = 1'b0;
    chk("div4_taken", {r4_valid, c4_ready}, 64'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
